// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: FSM states, func3 codes and request legality check shared by the SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} e_state;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants exist only for loads, so they are illegal on a store.
    function automatic logic f_bad_req(input logic wren, input logic [2:0] f3, input logic [1:0] a);
        return (f3 == F3_B)  ? 1'b0 :
               (f3 == F3_H)  ? a[0] :
               (f3 == F3_W)  ? |a :
               (f3 == F3_BU) ? wren :
               (f3 == F3_HU) ? (wren | a[0]) : 1'b1;
    endfunction

endpackage

// File: rtl/sram_ld_fmt.sv
// sram_ld_fmt: lane select and sign/zero extension of raw SRAM load data.
module sram_ld_fmt import sram_ctrl_pkg::*; (
    input  logic [2:0]  i_func3,
    input  logic        i_addr0,
    input  logic [31:0] i_raw,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte  = i_addr0 ? i_raw[15:8] : i_raw[7:0];
    assign w_half  = i_raw[15:0];
    assign o_rdata = (i_func3 == F3_B)  ? {{24{w_byte[7]}}, w_byte} :
                     (i_func3 == F3_BU) ? {24'h0, w_byte} :
                     (i_func3 == F3_H)  ? {{16{w_half[15]}}, w_half} :
                     (i_func3 == F3_HU) ? {16'h0, w_half} :
                     (i_func3 == F3_W)  ? i_raw : 32'h0;

endmodule

// File: rtl/sram_ctrl_gen.sv
// sram_ctrl_gen: LSU to 16-bit asynchronous SRAM controller with wait states and two-beat word accesses.
module sram_ctrl_gen import sram_ctrl_pkg::*; #(
    parameter int ADDR_W   = 18,
    parameter int WAIT_CYC = 2,
    parameter int CNT_W    = $clog2(WAIT_CYC + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_wren,
    input  logic [2:0]        i_func3,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_st_data,
    output logic [31:0]       o_rdata,
    output logic              o_ack,
    output logic              o_err,
    output logic              o_busy,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_UB_N
);

    e_state            r_state;
    logic              r_beat;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wren;
    logic [2:0]        r_func3;
    logic              r_a0;
    logic [31:0]       r_st;
    logic [15:0]       r_lo;
    logic [31:0]       r_rdata;
    logic              r_ack;
    logic              r_err;
    logic              r_busy;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic              r_lb_n;
    logic              r_ub_n;
    logic              r_dq_oe;
    logic [15:0]       r_dq;

    logic        w_byte_req;
    logic        w_word;
    logic        w_more;
    logic        w_last;
    logic [15:0] w_wdata;
    logic [31:0] w_raw;
    logic [31:0] w_fmt;
    logic        w_unused;

    assign w_byte_req = i_func3[1:0] == 2'b00;
    assign w_word     = r_func3 == F3_W;
    assign w_more     = w_word & ~r_beat;
    assign w_last     = r_cnt == CNT_W'(WAIT_CYC - 1);
    assign w_wdata    = (w_word & r_beat) ? r_st[31:16] :
                        (r_func3[1:0] == 2'b00) ? {r_st[7:0], r_st[7:0]} : r_st[15:0];
    assign w_raw      = w_word ? {SRAM_DQ, r_lo} : {16'h0, SRAM_DQ};
    assign w_unused   = ^i_addr[31:ADDR_W+1];

    sram_ld_fmt u_fmt (
        .i_func3 (r_func3),
        .i_addr0 (r_a0),
        .i_raw   (w_raw),
        .o_rdata (w_fmt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_beat  <= 1'b0;
            r_cnt   <= '0;
            r_wren  <= 1'b0;
            r_func3 <= 3'b000;
            r_a0    <= 1'b0;
            r_st    <= '0;
            r_lo    <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_lb_n  <= 1'b1;
            r_ub_n  <= 1'b1;
            r_dq_oe <= 1'b0;
            r_dq    <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_req) begin
                    r_wren  <= i_wren;
                    r_func3 <= i_func3;
                    r_a0    <= i_addr[0];
                    r_st    <= i_st_data;
                    r_beat  <= 1'b0;
                    r_busy  <= 1'b1;
                    if (f_bad_req(i_wren, i_func3, i_addr[1:0])) begin
                        r_state <= DONE;
                        r_ack   <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_state <= SETUP;
                        r_addr  <= i_addr[ADDR_W:1];
                        r_ce_n  <= 1'b0;
                        r_oe_n  <= i_wren;
                        r_lb_n  <= w_byte_req & i_addr[0];
                        r_ub_n  <= w_byte_req & ~i_addr[0];
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
                    r_cnt   <= '0;
                    r_we_n  <= ~r_wren;
                    r_dq_oe <= r_wren;
                    r_dq    <= w_wdata;
                end
                ACCESS: begin
                    if (!w_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (r_wren) begin
                        r_state <= HOLD;
                        r_we_n  <= 1'b1;
                    end else if (w_more) begin
                        r_lo    <= SRAM_DQ;
                        r_state <= SETUP;
                        r_beat  <= 1'b1;
                        r_addr  <= r_addr + 1'b1;
                    end else begin
                        r_rdata <= w_fmt;
                        r_state <= DONE;
                        r_ack   <= 1'b1;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_lb_n  <= 1'b1;
                        r_ub_n  <= 1'b1;
                    end
                end
                HOLD: begin
                    r_dq_oe <= 1'b0;
                    if (w_more) begin
                        r_state <= SETUP;
                        r_beat  <= 1'b1;
                        r_addr  <= r_addr + 1'b1;
                    end else begin
                        r_state <= DONE;
                        r_ack   <= 1'b1;
                        r_ce_n  <= 1'b1;
                        r_lb_n  <= 1'b1;
                        r_ub_n  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_rdata   = r_rdata;
    assign o_ack     = r_ack;
    assign o_err     = r_err;
    assign o_busy    = r_busy;
    assign SRAM_ADDR = r_addr;
    assign SRAM_DQ   = r_dq_oe ? r_dq : {16{1'bz}};
    assign SRAM_CE_N = r_ce_n;
    assign SRAM_OE_N = r_oe_n;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_LB_N = r_lb_n;
    assign SRAM_UB_N = r_ub_n;

endmodule
